// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor with a start/busy/done handshake.
// It computes diff = a - b - bin (mod 2^WIDTH) and borrow_out = (a < b + bin).
// One bit is processed per clock, LSB first, so one operation takes WIDTH clocks.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // The counter needs one extra bit so that WIDTH itself is representable.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             accept;
  logic             last_step;
  logic             x_bit;
  logic             y_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shifted;

  // Start is honoured in IDLE and DONE only; a start during RUN is ignored.
  assign accept    = (state_q != S_RUN) && start;
  assign last_step = (state_q == S_RUN) && (cnt_q == LAST_CNT);

  // One-bit subtract cell fed from the LSBs of the operand shift registers.
  always_comb begin
    x_bit       = a_q[0];
    y_bit       = b_q[0];
    d_bit       = x_bit ^ y_bit ^ br_q;
    br_next     = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    res_shifted = {d_bit, res_q[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = (cnt_q == LAST_CNT) ? S_DONE : S_RUN;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy and done are pure decodes of the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values: capture on accept, shift one bit per RUN clock,
  // publish the result on the final step so it holds through DONE and IDLE.
  always_comb begin
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    br_d     = br_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (accept) begin
      cnt_d = '0;
      a_d   = a;
      b_d   = b;
      br_d  = bin;
      res_d = '0;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + CNT_ONE;
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_next;
      res_d = res_shifted;
      if (last_step) begin
        diff_d   = res_shifted;
        borrow_d = br_next;
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      br_q     <= br_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule
